// File: rtl/stopwatch_controller.sv
// Stopwatch control sequencer: key synchronisation and debounce, run/pause/lap FSM,
// and the 100 Hz advance prescaler that drives the counter/display datapath.
//
// state  | meaning
// IDLE   | counter cleared, prescaler held at 0, display follows counter
// RUN    | counting, display follows counter
// PAUSED | counting frozen, prescaler phase held
// LAP    | counting, display frozen on the last snapshot
module stopwatch_controller #(
    parameter int CLK_DIV         = 500000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic       tick,
    output logic       clear,
    output logic       snap,
    output logic       disp_follow,
    output logic       running,
    output logic [1:0] state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = $clog2(CLK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10,
        S_LAP    = 2'b11
    } state_t;

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_db;
    logic [3:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [4];
    logic [3:0]      w_db_next;
    logic [3:0]      w_press_next;

    logic            w_ev3;
    logic            w_ev2;
    logic            w_ev1;
    logic            w_ev0;

    state_t          r_state;
    logic            r_clear;
    logic            r_snap;
    logic            r_follow;
    logic            r_running;
    logic [PS_W-1:0] r_ps;
    logic            r_tick;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        w_db_next = r_db;
        for (int i = 0; i < 4; i++) begin
            if ((r_sync2[i] != r_db[i]) && (r_db_cnt[i] == DB_LAST)) begin
                w_db_next[i] = r_sync2[i];
            end
        end
    end

    assign w_press_next = r_db & ~w_db_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_db    <= 4'b1111;
            r_press <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_db    <= w_db_next;
            r_press <= w_press_next;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    r_db_cnt[i] <= (r_db_cnt[i] == DB_LAST) ? '0 : r_db_cnt[i] + 1'b1;
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Fixed priority: clear-all beats start/pause beats lap beats unfreeze.
    assign w_ev3 = r_press[3];
    assign w_ev2 = r_press[2] & ~r_press[3];
    assign w_ev1 = r_press[1] & ~(|r_press[3:2]);
    assign w_ev0 = r_press[0] & ~(|r_press[3:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clear   <= 1'b0;
            r_snap    <= 1'b0;
            r_follow  <= 1'b1;
            r_running <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            r_snap  <= 1'b0;
            if (w_ev3) begin
                r_state   <= S_IDLE;
                r_follow  <= 1'b1;
                r_running <= 1'b0;
                r_clear   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ev2) begin
                            r_state   <= S_RUN;
                            r_follow  <= 1'b1;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_ev2) begin
                            r_state   <= S_PAUSED;
                            r_follow  <= 1'b1;
                            r_running <= 1'b0;
                        end else if (w_ev1) begin
                            r_state   <= S_LAP;
                            r_follow  <= 1'b0;
                            r_running <= 1'b1;
                            r_snap    <= 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (w_ev2) begin
                            r_state   <= S_RUN;
                            r_follow  <= 1'b1;
                            r_running <= 1'b1;
                        end
                    end
                    S_LAP: begin
                        if (w_ev2) begin
                            r_state   <= S_PAUSED;
                            r_follow  <= 1'b1;
                            r_running <= 1'b0;
                        end else if (w_ev1) begin
                            r_snap <= 1'b1;
                        end else if (w_ev0) begin
                            r_state   <= S_RUN;
                            r_follow  <= 1'b1;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_follow  <= 1'b1;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gated by the pre-transition state, so a pause on the wrap edge still ticks;
    // a clear on that edge zeroes the phase and drops the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_ev3 || (r_state == S_IDLE)) begin
                r_ps <= '0;
            end else if ((r_state == S_RUN) || (r_state == S_LAP)) begin
                if (r_ps == PS_LAST) begin
                    r_ps   <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_ps <= r_ps + 1'b1;
                end
            end
        end
    end

    assign tick        = r_tick;
    assign clear       = r_clear;
    assign snap        = r_snap;
    assign disp_follow = r_follow;
    assign running     = r_running;
    assign state       = r_state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: a key/transition vector table, a bounce sequence and
// a cycle-exact timeline, all checked through a cycle-stamped expectation queue.
module tb_stopwatch_controller;

    localparam int DB  = 4;
    localparam int DIV = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       tick, clear, snap, disp_follow, running;
    logic [1:0] state;

    stopwatch_controller #(.CLK_DIV(DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .tick        (tick),
        .clear       (clear),
        .snap        (snap),
        .disp_follow (disp_follow),
        .running     (running),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      tag;
        int         cyc;
        logic       chk_tick;
        logic       tick;
        logic       clear;
        logic       snap;
        logic       follow;
        logic       running;
        logic [1:0] state;
    } exp_t;

    typedef struct {
        logic [3:0] k;
        logic [1:0] st;
        logic       cl;
        logic       sn;
    } vec_t;

    typedef struct {
        int         lo;
        int         hi;
        logic [1:0] st;
        int         t0;
    } seg_t;

    typedef struct {
        int         at;
        int         rel;
        logic [3:0] k;
        logic       with_rst;
    } ev_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void push(string tag, int c, logic [1:0] st, logic ct, logic tk,
                                 logic cl, logic sn);
        exp_t e;
        e.tag      = tag;
        e.cyc      = c;
        e.chk_tick = ct;
        e.tick     = tk;
        e.clear    = cl;
        e.snap     = sn;
        e.follow   = (st != 2'b11);
        e.running  = (st == 2'b01) || (st == 2'b11);
        e.state    = st;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || state !== e.state || clear !== e.clear || snap !== e.snap ||
                disp_follow !== e.follow || running !== e.running ||
                (e.chk_tick && tick !== e.tick)) begin
                bad++;
                $display("FAIL %s @%0d (want @%0d): got st=%b tk=%b cl=%b sn=%b fo=%b ru=%b, want st=%b tk=%b cl=%b sn=%b fo=%b ru=%b",
                         e.tag, cyc, e.cyc, state, tick, clear, snap, disp_follow, running,
                         e.state, e.chk_tick ? e.tick : tick, e.clear, e.snap, e.follow, e.running);
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: stuck at cycle %0d, want end before 20000", cyc);
        $fatal(1);
    end

    vec_t vecs [20];
    seg_t segs [13];
    ev_t  evs  [11];

    initial begin
        int         p, q, b;
        logic [1:0] prev;
        logic [1:0] st;
        logic       tk;

        vecs = '{
            '{4'b1101, 2'b00, 1'b0, 1'b0},   // key1 in IDLE: ignored
            '{4'b1110, 2'b00, 1'b0, 1'b0},   // key0 in IDLE: ignored
            '{4'b1011, 2'b01, 1'b0, 1'b0},
            '{4'b1110, 2'b01, 1'b0, 1'b0},
            '{4'b1101, 2'b11, 1'b0, 1'b1},
            '{4'b1101, 2'b11, 1'b0, 1'b1},   // re-capture
            '{4'b1110, 2'b01, 1'b0, 1'b0},
            '{4'b1011, 2'b10, 1'b0, 1'b0},
            '{4'b1101, 2'b10, 1'b0, 1'b0},
            '{4'b1110, 2'b10, 1'b0, 1'b0},
            '{4'b1011, 2'b01, 1'b0, 1'b0},
            '{4'b1101, 2'b11, 1'b0, 1'b1},
            '{4'b1011, 2'b10, 1'b0, 1'b0},
            '{4'b0111, 2'b00, 1'b1, 1'b0},
            '{4'b0111, 2'b00, 1'b1, 1'b0},
            '{4'b1100, 2'b00, 1'b0, 1'b0},
            '{4'b1001, 2'b01, 1'b0, 1'b0},   // key2 beats key1
            '{4'b1100, 2'b11, 1'b0, 1'b1},   // key1 beats key0
            '{4'b1010, 2'b10, 1'b0, 1'b0},   // key2 beats key0
            '{4'b0011, 2'b00, 1'b1, 1'b0}    // key3 beats key2
        };

        segs = '{
            '{  0,  15, 2'b00,  -1},
            '{ 16,  57, 2'b01,  21},
            '{ 58,  77, 2'b10,  -1},
            '{ 78, 105, 2'b01,  81},
            '{106, 120, 2'b11, 106},
            '{121, 134, 2'b00,  -1},
            '{135, 149, 2'b01, 140},
            '{150, 150, 2'b10, 150},
            '{151, 171, 2'b10,  -1},
            '{172, 186, 2'b01, 177},
            '{187, 197, 2'b11, 187},
            '{198, 221, 2'b00,  -1},
            '{222, 232, 2'b01, 227}
        };

        evs = '{
            '{  9,  35, 4'b1011, 1'b0},
            '{ 51,  57, 4'b1011, 1'b0},
            '{ 71,  77, 4'b1011, 1'b0},
            '{ 99, 105, 4'b1101, 1'b0},
            '{114, 120, 4'b0011, 1'b0},
            '{128, 134, 4'b1011, 1'b0},
            '{143, 149, 4'b1011, 1'b0},
            '{165, 171, 4'b1011, 1'b0},
            '{180, 186, 4'b1101, 1'b0},
            '{195, 197, 4'b1011, 1'b1},
            '{215, 221, 4'b1011, 1'b0}
        };

        repeat (3) @(posedge clk);
        #1;
        push("reset", cyc, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_to(cyc + 4);

        prev = 2'b00;
        for (int i = 0; i < 20; i++) begin
            p = cyc;
            key_n = vecs[i].k;
            push($sformatf("vec%0d_pre", i), p + 6, prev, 1'b0, 1'b0, 1'b0, 1'b0);
            push($sformatf("vec%0d_edge", i), p + 7, vecs[i].st, 1'b0, 1'b0, vecs[i].cl, vecs[i].sn);
            push($sformatf("vec%0d_post", i), p + 8, vecs[i].st, 1'b0, 1'b0, 1'b0, 1'b0);
            wait_to(p + 6);
            key_n = 4'hF;
            wait_to(p + 14);
            prev = vecs[i].st;
        end

        p = cyc;
        q = p + 12;
        for (int c = p; c <= q + 10; c++) begin
            st = (c >= q + 7) ? 2'b01 : 2'b00;
            push("bounce", c, st, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        key_n = 4'b1011;
        wait_to(p + 3);
        key_n = 4'hF;
        wait_to(p + 4);
        key_n = 4'b1011;
        wait_to(p + 7);
        key_n = 4'hF;
        wait_to(q);
        key_n = 4'b1011;
        wait_to(q + 4);
        key_n = 4'hF;
        wait_to(q + 14);

        rst = 1'b1;
        @(posedge clk);
        #1;
        b = cyc;
        rst = 1'b0;
        for (int c = 0; c <= 232; c++) begin
            st = 2'b00;
            tk = 1'b0;
            foreach (segs[s]) begin
                if (c >= segs[s].lo && c <= segs[s].hi) begin
                    st = segs[s].st;
                    tk = (segs[s].t0 >= 0) && (c >= segs[s].t0) && ((c - segs[s].t0) % DIV == 0);
                end
            end
            push($sformatf("tl%0d", c), b + c, st, 1'b1, tk, (c == 121),
                 (c == 106) || (c == 187));
        end
        foreach (evs[n]) begin
            wait_to(b + evs[n].at);
            key_n = evs[n].k;
            wait_to(b + evs[n].rel);
            key_n = 4'hF;
            if (evs[n].with_rst) begin
                rst = 1'b1;
                wait_to(b + evs[n].rel + 1);
                rst = 1'b0;
            end
        end
        wait_to(b + 234);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
